polarity_event_arbiter: RTL and testbench
=========================================

# polarity_event_arbiter

Round-robin arbiter that shares the single event output channel between `NUM_REQ` pixel requesters, each presenting a 2-bit ON/OFF polarity request. It sits between the pixel request array and the downstream event encoder/FIFO. It resolves each winning request into an address plus a 1-bit polarity, transfers that event over a valid/ready handshake, and returns a one-cycle grant pulse to the winning requester so the requester can clear its request.

## Interface
Parameters:
- `NUM_REQ`, 16: number of requesters (≥2).
- `ADDR_W`, $clog2(NUM_REQ): width of the event address.
- `POLARITY`, 2: request width per requester, taken from `arbiter_pkg`.
- `CNT_W`, 16: width of the accepted-event counter.

Ports:
- `clk_i`: input, 1 bit. Single clock; everything is rising-edge.
- `reset_i`: input, 1 bit. Reset is asynchronous and active-low.
- `en_i`: input, 1 bit. Arbitration enable.
- `req_i`: input, `NUM_REQ`×`POLARITY` bits. Per-requester polarity request: 2'b10 = ON, 2'b01 = OFF.
- `ready_i`: input, 1 bit. Downstream can accept an event.
- `valid_o`: output, 1 bit. Event on `addr_o`/`pol_o` is valid.
- `addr_o`: output, `ADDR_W` bits. Index of the granted requester.
- `pol_o`: output, 1 bit. 1 = ON (2'b10); 0 = OFF (2'b01) or conflict (2'b11).
- `gnt_o`: output, `NUM_REQ` bits. One-hot grant/acknowledge pulse.
- `conflict_o`: output, 1 bit. One-cycle pulse when the latched request was 2'b11.
- `evt_cnt_o`: output, `CNT_W` bits. Count of accepted events.

## Operation
- A requester is active when its `req_i` slice is non-zero.
- Polarity mapping:
  - 2'b10 → 1.
  - 2'b01 → 0.
  - 2'b11 → 0, and `conflict_o` pulses in the cycle the event is latched.
- FSM has three states: IDLE, SEND, ACK.
- IDLE:
  - Stay in IDLE if `en_i`=0 or there are no active requesters.
  - Otherwise, select the first active index searching upward from `ptr` and wrapping modulo `NUM_REQ`.
  - Register that index into `addr_o` and its mapped polarity into `pol_o`, set `valid_o`=1, and go to SEND.
- SEND:
  - Hold `valid_o`, `addr_o` and `pol_o` stable until `ready_i`=1.
  - On the accept cycle (`valid_o` & `ready_i`): clear `valid_o`, set `gnt_o[addr_o]`=1, increment `evt_cnt_o`, set `ptr` = `addr_o`+1 (wrapping NUM_REQ-1 → 0), and go to ACK.
  - A change on `req_i` during SEND does not alter the held event.
- ACK:
  - `gnt_o` is high for exactly this one cycle.
  - Always go to IDLE next. This gives the requester one cycle to drop its request before re-arbitration.
- `en_i` is sampled only in IDLE. Deasserting `en_i` mid-transaction does not abort SEND or ACK.
- `evt_cnt_o` wraps from 2^`CNT_W`-1 to 0 with no saturation or flag.
- At most one bit of `gnt_o` is ever set. `gnt_o` is never set while `valid_o`=1.

## Timing
- Reset (asynchronous, `reset_i`=0) forces:
  - state = IDLE;
  - `valid_o`=0, `addr_o`=0, `pol_o`=0, `gnt_o`=0, `conflict_o`=0;
  - `evt_cnt_o`=0;
  - `ptr`=0, so index 0 has first priority.
- Reset mid-SEND or mid-ACK drops the event with no grant. Operation resumes in IDLE on the first edge after release.
- Latency: request visible in IDLE at edge t → `valid_o`=1 after edge t.
- With `ready_i` held at 1, accept happens at edge t+1, `gnt_o` is high during t+1..t+2, and the next arbitration happens at edge t+3. Peak rate is one event per 3 cycles.
- `ready_i` may be high before `valid_o`. Only the cycle where both are high counts as an accept.
- Outputs are all registered. There is no combinational path from `req_i` or `ready_i` to any output.

## Test plan
- **Reset:** assert `reset_i`=0 mid-SEND with `addr_o`=5 → all outputs 0 immediately. After release, `req_i[0]`=2'b10 → `addr_o`=0, `pol_o`=1.
- **Single request, fixed latency:** `req_i[3]`=2'b01, `ready_i`=1 → `valid_o` one cycle later with `addr_o`=3 and `pol_o`=0, `gnt_o`=16'h0008 for exactly one cycle, `evt_cnt_o`=1.
- **Round-robin fairness:** requesters 2, 7 and 15 held active, `ready_i`=1 → grant order 2, 7, 15, 2 …, and each index gets a grant within `NUM_REQ` events.
- **Backpressure:** `ready_i`=0 for 10 cycles while `req_i` changes → `valid_o`, `addr_o` and `pol_o` stay constant and `gnt_o`=0 throughout. Raising `ready_i` gives exactly one grant.
- **Conflict and wrap:** `req_i[15]`=2'b11 → `pol_o`=0, one `conflict_o` pulse, and the next search starts at index 0.
- **Enable and counter wrap:** with `en_i`=0, no `valid_o` appears. Preload the count via 65535 accepts → the next accept gives `evt_cnt_o`=0.

Source files
------------

// File: rtl/polarity_event_arbiter.sv
// -----------------------------------------------------------------------------
// polarity_event_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one event output channel between NUM_REQ
//   pixel requesters. Each requester presents a 2-bit polarity request
//   (2'b10 = ON, 2'b01 = OFF, 2'b11 = conflicting ON+OFF). The winner is
//   turned into an address plus a 1-bit polarity and handed downstream over a
//   valid/ready handshake. Once the event is accepted, the winner gets a
//   one-cycle one-hot grant pulse so it can clear its request.
//
//   Transaction shape (ready_i held high):
//     edge t   : IDLE picks a winner, valid_o rises
//     edge t+1 : accept, valid_o falls, gnt_o pulses for one cycle (ACK)
//     edge t+2 : back to IDLE (requester has had one cycle to drop its request)
//     edge t+3 : next arbitration
//
// Ports:
//   clk_i       in   clock, rising edge
//   reset_i     in   asynchronous reset, active low
//   en_i        in   arbitration enable, only looked at in IDLE
//   req_i       in   NUM_REQ x POLARITY request slices, slice i = requester i
//   ready_i     in   downstream can take an event
//   valid_o     out  event on addr_o/pol_o is valid
//   addr_o      out  index of the granted requester
//   pol_o       out  1 = ON, 0 = OFF or conflict
//   gnt_o       out  one-hot acknowledge pulse to the winning requester
//   conflict_o  out  one-cycle pulse when the latched request was 2'b11
//   evt_cnt_o   out  free-running count of accepted events (wraps)
// -----------------------------------------------------------------------------

package arbiter_pkg;
   localparam int POLARITY = 2;
endpackage

module polarity_event_arbiter #(
   parameter int NUM_REQ  = 16,
   parameter int ADDR_W   = $clog2(NUM_REQ),
   parameter int POLARITY = arbiter_pkg::POLARITY,
   parameter int CNT_W    = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        en_i,
   input  logic [NUM_REQ*POLARITY-1:0] req_i,
   input  logic                        ready_i,
   output logic                        valid_o,
   output logic [ADDR_W-1:0]           addr_o,
   output logic                        pol_o,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic                        conflict_o,
   output logic [CNT_W-1:0]            evt_cnt_o
);

   localparam logic [POLARITY-1:0] REQ_ON       = POLARITY'(2'b10);
   localparam logic [POLARITY-1:0] REQ_CONFLICT = POLARITY'(2'b11);
   localparam logic [ADDR_W-1:0]   LAST_IDX     = ADDR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_valid;
   logic                 w_valid_nxt;
   logic [ADDR_W-1:0]    r_addr;
   logic [ADDR_W-1:0]    w_addr_nxt;
   logic                 r_pol;
   logic                 w_pol_nxt;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   w_gnt_nxt;
   logic                 r_conflict;
   logic                 w_conflict_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [ADDR_W-1:0]    r_ptr;
   logic [ADDR_W-1:0]    w_ptr_nxt;

   logic [NUM_REQ-1:0]   w_active;
   logic                 w_found;
   logic [ADDR_W-1:0]    w_sel_idx;
   logic [POLARITY-1:0]  w_sel_req;
   logic                 w_sel_pol;
   logic                 w_sel_conflict;

   // A requester is active whenever any bit of its slice is set.
   always_comb begin
      w_active = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_active[i] = |req_i[i*POLARITY +: POLARITY];
      end
   end

   // Rotating priority search. The first pass only considers indices at or
   // above the pointer; if nothing is found there, the second pass takes the
   // lowest active index, which is exactly the wrapped-around continuation of
   // the search. This avoids modulo arithmetic for non-power-of-two NUM_REQ.
   always_comb begin
      w_found   = 1'b0;
      w_sel_idx = '0;
      w_sel_req = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && w_active[j] && (ADDR_W'(j) >= r_ptr)) begin
            w_found   = 1'b1;
            w_sel_idx = ADDR_W'(j);
            w_sel_req = req_i[j*POLARITY +: POLARITY];
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && w_active[j]) begin
            w_found   = 1'b1;
            w_sel_idx = ADDR_W'(j);
            w_sel_req = req_i[j*POLARITY +: POLARITY];
         end
      end
   end

   // Only a pure ON request maps to 1; OFF and conflict both map to 0.
   assign w_sel_pol      = (w_sel_req == REQ_ON);
   assign w_sel_conflict = (w_sel_req == REQ_CONFLICT);

   // Next-state and next-output logic. Every output is taken from a register,
   // so nothing here reaches a port combinationally.
   always_comb begin
      w_state_nxt    = r_state;
      w_valid_nxt    = r_valid;
      w_addr_nxt     = r_addr;
      w_pol_nxt      = r_pol;
      w_gnt_nxt      = '0;
      w_conflict_nxt = 1'b0;
      w_cnt_nxt      = r_cnt;
      w_ptr_nxt      = r_ptr;

      case (r_state)
         ST_IDLE: begin
            if (en_i && w_found) begin
               w_addr_nxt     = w_sel_idx;
               w_pol_nxt      = w_sel_pol;
               w_conflict_nxt = w_sel_conflict;
               w_valid_nxt    = 1'b1;
               w_state_nxt    = ST_SEND;
            end
         end

         // The event was captured on entry, so req_i changes here are ignored.
         ST_SEND: begin
            if (ready_i) begin
               w_valid_nxt = 1'b0;
               w_gnt_nxt   = NUM_REQ'(1) << r_addr;
               w_cnt_nxt   = r_cnt + 1'b1;
               w_ptr_nxt   = (r_addr == LAST_IDX) ? '0 : r_addr + 1'b1;
               w_state_nxt = ST_ACK;
            end
         end

         // Grant is visible for this one cycle; the extra hop through IDLE
         // gives the requester time to withdraw before it could win again.
         ST_ACK: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state    <= ST_IDLE;
         r_valid    <= 1'b0;
         r_addr     <= '0;
         r_pol      <= 1'b0;
         r_gnt      <= '0;
         r_conflict <= 1'b0;
         r_cnt      <= '0;
         r_ptr      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_valid    <= w_valid_nxt;
         r_addr     <= w_addr_nxt;
         r_pol      <= w_pol_nxt;
         r_gnt      <= w_gnt_nxt;
         r_conflict <= w_conflict_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
      end
   end

   assign valid_o    = r_valid;
   assign addr_o     = r_addr;
   assign pol_o      = r_pol;
   assign gnt_o      = r_gnt;
   assign conflict_o = r_conflict;
   assign evt_cnt_o  = r_cnt;

   // Structural invariants of the handshake.
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!reset_i)
      $onehot0(gnt_o));

   a_gnt_not_with_valid : assert property (@(posedge clk_i) disable iff (!reset_i)
      !(valid_o && (|gnt_o)));

endmodule

// File: tb/tb_polarity_event_arbiter.sv
module tb_polarity_event_arbiter;

   localparam int NREQ  = 16;
   localparam int AW    = 4;
   localparam int CNT_W = 8;
   localparam int CMOD  = 1 << CNT_W;

   logic                 clk_i;
   logic                 reset_i;
   logic                 en_i;
   logic [2*NREQ-1:0]    req_i;
   logic                 ready_i;
   logic                 valid_o;
   logic [AW-1:0]        addr_o;
   logic                 pol_o;
   logic [NREQ-1:0]      gnt_o;
   logic                 conflict_o;
   logic [CNT_W-1:0]     evt_cnt_o;

   polarity_event_arbiter #(
      .NUM_REQ (NREQ),
      .CNT_W   (CNT_W)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (en_i),
      .req_i      (req_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .addr_o     (addr_o),
      .pol_o      (pol_o),
      .gnt_o      (gnt_o),
      .conflict_o (conflict_o),
      .evt_cnt_o  (evt_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int addr;
      bit pol;
      bit conf;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   cur_live;
   bit   prev_valid;
   bit   prev_gnt;

   int   errors = 0;
   int   checks = 0;
   int   m_ptr  = 0;
   int   m_cnt  = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic logic [1:0] slice_of(input logic [2*NREQ-1:0] v, input int i);
      return 2'(v >> (2 * i));
   endfunction

   // Reference: first requester with a non-zero slice, scanning upward from p.
   function automatic int pick(input logic [2*NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (slice_of(v, (p + k) % NREQ) != 2'b00) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // Drive a request vector and, if the arbiter will act on it, queue the
   // event it must produce. Called only when the next sampling IDLE edge will
   // see this vector unchanged.
   task automatic issue(input logic [2*NREQ-1:0] v);
      exp_t e;
      int   w;
      req_i = v;
      if (!en_i) return;
      w = pick(v, m_ptr);
      if (w < 0) return;
      e.addr = w;
      e.pol  = (slice_of(v, w) == 2'b10);
      e.conf = (slice_of(v, w) == 2'b11);
      m_cnt  = (m_cnt + 1) % CMOD;
      e.cnt  = m_cnt;
      m_ptr  = (w + 1) % NREQ;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input bit rand_ready, output int idx, output int lat);
      bit got;
      got = 1'b0;
      idx = -1;
      lat = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk_i);
         lat++;
         if (gnt_o != '0) begin
            got = 1'b1;
            for (int b = 0; b < NREQ; b++) if (gnt_o[b]) idx = b;
         end else if (rand_ready) begin
            ready_i = 1'($urandom_range(0, 1));
         end
      end
      if (!got) begin
         chk("grant_timeout", got, 1);
         finish_run();
      end
   endtask

   task automatic wait_valid();
      bit got;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk_i);
         got = valid_o;
      end
      if (!got) begin
         chk("valid_timeout", got, 1);
         finish_run();
      end
   endtask

   // Monitor: pops an expectation whenever a new event appears and checks the
   // grant that closes it.
   always @(negedge clk_i) begin
      if (!reset_i) begin
         prev_valid = 1'b0;
         prev_gnt   = 1'b0;
         cur_live   = 1'b0;
      end else begin
         if (valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", valid_o, 0);
            end else begin
               cur      = exp_q.pop_front();
               cur_live = 1'b1;
               chk("evt_addr", addr_o, cur.addr);
               chk("evt_pol", pol_o, cur.pol);
               chk("evt_conflict", conflict_o, cur.conf);
            end
         end else if (valid_o) begin
            chk("hold_addr", addr_o, cur.addr);
            chk("hold_pol", pol_o, cur.pol);
            chk("conflict_len", conflict_o, 0);
         end else if (conflict_o) begin
            chk("conflict_without_valid", conflict_o, 0);
         end
         if (gnt_o != '0) begin
            chk("gnt_with_valid", valid_o, 0);
            chk("gnt_len", prev_gnt, 0);
            if (!cur_live) begin
               chk("spurious_gnt", gnt_o, 0);
            end else begin
               chk("gnt_vec", gnt_o, 1 << cur.addr);
               chk("evt_cnt", evt_cnt_o, cur.cnt);
            end
            cur_live = 1'b0;
         end
         prev_valid = valid_o;
         prev_gnt   = (gnt_o != '0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2*NREQ-1:0] v;
      int idx, lat, gcount, guard;
      int fair_order[4];

      fair_order = '{2, 7, 15, 2};
      reset_i = 1'b0;
      en_i    = 1'b1;
      ready_i = 1'b0;
      req_i   = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_valid", valid_o, 0);
      chk("rst_gnt", gnt_o, 0);
      chk("rst_cnt", evt_cnt_o, 0);
      reset_i = 1'b1;

      // Single OFF request on requester 3, ready already high.
      @(negedge clk_i);
      ready_i = 1'b1;
      v = '0; v[7:6] = 2'b01;
      issue(v);
      wait_grant(1'b0, idx, lat);
      chk("single_idx", idx, 3);
      chk("single_latency", lat, 2);
      chk("single_gnt", gnt_o, 16'h0008);
      chk("single_cnt", evt_cnt_o, 1);
      issue('0);
      @(negedge clk_i);
      chk("single_gnt_drop", gnt_o, 0);

      // Reset in the middle of SEND with addr 5 pending.
      ready_i = 1'b0;
      v = '0; v[11:10] = 2'b10;
      issue(v);
      wait_valid();
      chk("pre_rst_addr", addr_o, 5);
      @(negedge clk_i);
      #2 reset_i = 1'b0;
      #1;
      chk("midrst_valid", valid_o, 0);
      chk("midrst_addr", addr_o, 0);
      chk("midrst_pol", pol_o, 0);
      chk("midrst_gnt", gnt_o, 0);
      chk("midrst_conflict", conflict_o, 0);
      chk("midrst_cnt", evt_cnt_o, 0);
      exp_q.delete();
      m_ptr = 0;
      m_cnt = 0;
      @(negedge clk_i);
      reset_i = 1'b1;
      ready_i = 1'b1;
      v = '0; v[1:0] = 2'b10; v[11:10] = 2'b10;
      issue(v);
      wait_grant(1'b0, idx, lat);
      chk("post_rst_idx", idx, 0);

      // Round-robin over held requesters 2, 7, 15.
      v = '0; v[5:4] = 2'b10; v[15:14] = 2'b01; v[31:30] = 2'b10;
      for (int k = 0; k < 4; k++) begin
         issue(v);
         wait_grant(1'b0, idx, lat);
         chk("rr_order", idx, fair_order[k]);
         chk("rr_latency", lat, 3);
      end

      // Conflict on 15, then the search wraps to 0.
      v = '0; v[31:30] = 2'b11; v[1:0] = 2'b10;
      issue(v);
      wait_grant(1'b0, idx, lat);
      chk("conflict_idx", idx, 15);
      v[31:30] = 2'b00;
      issue(v);
      wait_grant(1'b0, idx, lat);
      chk("wrap_idx", idx, 0);
      issue('0);
      @(negedge clk_i);

      // Backpressure: hold 10 cycles while requests churn.
      ready_i = 1'b0;
      v = '0; v[19:18] = 2'b01;
      issue(v);
      wait_valid();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         req_i = {$urandom, $urandom} [2*NREQ-1:0];
         chk("bp_valid_held", valid_o, 1);
         chk("bp_no_gnt", gnt_o, 0);
      end
      req_i   = '0;
      ready_i = 1'b1;
      gcount  = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         if (gnt_o != '0) gcount++;
      end
      chk("bp_grant_count", gcount, 1);

      // Enable low: nothing may start; enable dropped mid-SEND does not abort.
      en_i  = 1'b0;
      v = '0; v[13:12] = 2'b10;
      req_i = v;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         chk("en_off_valid", valid_o, 0);
      end
      en_i    = 1'b1;
      ready_i = 1'b0;
      issue(v);
      wait_valid();
      en_i = 1'b0;
      repeat (2) @(negedge clk_i);
      ready_i = 1'b1;
      wait_grant(1'b0, idx, lat);
      chk("en_midsend_idx", idx, 6);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         chk("en_off_again_valid", valid_o, 0);
      end
      en_i = 1'b1;
      issue(v);
      wait_grant(1'b0, idx, lat);

      // Randomized traffic with random backpressure.
      for (int n = 0; n < 150; n++) begin
         v = req_i;
         v[2*idx +: 2] = 2'b00;
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) v[2*i +: 2] = 2'($urandom_range(0, 3));
         end
         issue(v);
         if (pick(v, m_ptr) < 0) begin
            repeat (2) @(negedge clk_i);
            v[2*$urandom_range(0, NREQ-1) +: 2] = 2'($urandom_range(1, 3));
            issue(v);
         end
         wait_grant(1'b1, idx, lat);
      end
      ready_i = 1'b1;

      // Drive the counter up to its top value, then across the wrap.
      v = '0; v[9:8] = 2'b01;
      guard = 0;
      while (m_cnt != CMOD - 1 && guard < 400) begin
         issue(v);
         wait_grant(1'b0, idx, lat);
         guard++;
      end
      chk("cnt_top", evt_cnt_o, CMOD - 1);
      issue(v);
      wait_grant(1'b0, idx, lat);
      chk("cnt_wrap", evt_cnt_o, 0);
      issue('0);
      repeat (5) @(negedge clk_i);
      chk("queue_drained", exp_q.size(), 0);
      finish_run();
   end

endmodule
